// File: rtl/imem_loader_pkg.sv
// Shared encodings for the instruction-memory UART loader: loader FSM states
// and UART receiver bit phases.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_START,
    PH_DATA,
    PH_STOP
  } rx_phase_t;

  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, bit-centre sampling, glitch
// rejection on the start bit, one-cycle valid / frame-error pulses.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Rx,
  output logic [7:0] o_Byte,
  output logic       o_Valid,
  output logic       o_Frame_err
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_meta, rx_sync, rx_prev;
  rx_phase_t phase;
  logic [TW-1:0] timer;
  logic [2:0] bit_cnt;
  logic [7:0] shift;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_Rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      phase       <= PH_IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_Byte      <= '0;
      o_Valid     <= 1'b0;
      o_Frame_err <= 1'b0;
    end else begin
      o_Valid     <= 1'b0;
      o_Frame_err <= 1'b0;
      case (phase)
        PH_IDLE: begin
          timer   <= '0;
          bit_cnt <= '0;
          if (rx_prev && !rx_sync) phase <= PH_START;
        end
        PH_START: begin
          if (timer == T_HALF) begin
            timer <= '0;
            // A line that is high again at mid-start-bit was only a glitch.
            phase <= rx_sync ? PH_IDLE : PH_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PH_DATA: begin
          if (timer == T_FULL) begin
            timer   <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) phase <= PH_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        PH_STOP: begin
          if (timer == T_FULL) begin
            timer <= '0;
            phase <= PH_IDLE;
            if (rx_sync) begin
              o_Byte  <= shift;
              o_Valid <= 1'b1;
            end else begin
              o_Frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Fills instruction memory from a UART frame (LEN_LO, LEN_HI, 4*N LE bytes) and
// holds the CPU until done. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_uart_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned WORDS        = 256
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic              i_Rx,
  input  logic              i_Start,
  output logic              o_Wr_en,
  output logic [ADDR_W-1:0] o_Wr_addr,
  output logic [31:0]       o_Wr_data,
  output logic              o_Cpu_hold,
  output logic              o_Done,
  output logic              o_Error,
  output logic [15:0]       o_Count
);

  localparam logic [15:0] WORDS_L = 16'(WORDS);

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;
  ld_state_t   state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Rx       (i_Rx),
    .o_Byte     (rx_byte),
    .o_Valid    (rx_valid),
    .o_Frame_err(rx_ferr)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= ST_LEN_LO;
      o_Wr_en    <= 1'b0;
      o_Wr_addr  <= '0;
      o_Wr_data  <= '0;
      o_Cpu_hold <= 1'b1;
      o_Done     <= 1'b0;
      o_Error    <= 1'b0;
      o_Count    <= '0;
      len_lo     <= '0;
      len        <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      o_Wr_en <= 1'b0;
      case (state)
        ST_LEN_LO: begin
          if (rx_ferr) begin
            state   <= ST_ERR;
            o_Error <= 1'b1;
          end else if (rx_valid) begin
            len_lo <= rx_byte;
            state  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_ferr) begin
            state   <= ST_ERR;
            o_Error <= 1'b1;
          end else if (rx_valid) begin
            len <= {rx_byte, len_lo};
            if ({rx_byte, len_lo} > WORDS_L) begin
              state   <= ST_ERR;
              o_Error <= 1'b1;
            end else if ({rx_byte, len_lo} == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= ST_CSUM;
`else
              state      <= ST_DONE;
              o_Done     <= 1'b1;
              o_Cpu_hold <= 1'b0;
`endif
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_ferr) begin
            state   <= ST_ERR;
            o_Error <= 1'b1;
          end else if (rx_valid) begin
            byte_idx <= byte_idx + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_byte;
`endif
            if (byte_idx == 2'd3) begin
              o_Wr_en   <= 1'b1;
              o_Wr_addr <= o_Count[ADDR_W-1:0];
              o_Wr_data <= {rx_byte, word_buf};
              o_Count   <= o_Count + 16'd1;
            end else begin
              word_buf <= {rx_byte, word_buf[23:8]};
            end
          end else if (o_Wr_en && o_Count == len) begin
            // Count already reflects the write issued last cycle.
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= ST_CSUM;
`else
            state      <= ST_DONE;
            o_Done     <= 1'b1;
            o_Cpu_hold <= 1'b0;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (rx_ferr) begin
            state   <= ST_ERR;
            o_Error <= 1'b1;
          end else if (rx_valid) begin
            if (rx_byte == csum) begin
              state      <= ST_DONE;
              o_Done     <= 1'b1;
              o_Cpu_hold <= 1'b0;
            end else begin
              state   <= ST_ERR;
              o_Error <= 1'b1;
            end
          end
        end
`endif
        ST_DONE, ST_ERR: begin
          if (i_Start) begin
            state      <= ST_LEN_LO;
            o_Done     <= 1'b0;
            o_Error    <= 1'b0;
            o_Cpu_hold <= 1'b1;
            o_Count    <= '0;
            byte_idx   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        default: begin
          state   <= ST_ERR;
          o_Error <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_uart_loader.md
Name: imem_uart_loader

Overview:
- Writer side of the instruction-memory interface. The single-cycle CPU core only ever reads instruction memory; this block fills it.
- Receives a framed program image over a UART RX line, assembles little-endian 32-bit words, and issues one-cycle write strobes to the instruction-memory write port.
- Holds the CPU (o_Cpu_hold) until the image is complete.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4.
- ADDR_W, 8, instruction-memory word-address width.
- WORDS, 256, memory depth in words; must be ≤ 2**ADDR_W.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_Rx  in  1  UART serial line, idle high, asynchronous to i_Clk.
- i_Start  in  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- o_Wr_en  out  1  instruction-memory write strobe, one cycle per word.
- o_Wr_addr  out  ADDR_W  word address for the write.
- o_Wr_data  out  32  word data for the write.
- o_Cpu_hold  out  1  high keeps the PC/CPU frozen.
- o_Done  out  1  image loaded successfully; level signal.
- o_Error  out  1  framing, length or checksum failure; level signal.
- o_Count  out  16  words written so far, for the 7-seg display.

Behaviour:
- Reset values: o_Wr_en=0, o_Wr_addr=0, o_Wr_data=0, o_Cpu_hold=1, o_Done=0, o_Error=0, o_Count=0. FSM enters LEN_LO.
  - Reset does not clear instruction-memory contents.
  - Reset mid-transfer aborts it cleanly; the next frame starts from LEN_LO.
- i_Rx passes through a 2-flop synchronizer before any use.
- Byte receiver, 8N1, LSB first:
  - Falling edge of the synchronized line starts a receive.
  - Re-check the line at CLKS_PER_BIT/2. If it is high, treat it as a glitch and return to idle with no error.
  - Sample each data bit and the stop bit at bit-centre.
  - Stop bit = 0 is a frame error: the FSM goes to ERR.
  - On a good stop bit, byte_valid pulses for 1 cycle.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N data bytes (byte0 = bits 7:0).
- FSM states: LEN_LO, LEN_HI, DATA, [CSUM], DONE, ERR.
  - LEN_LO → LEN_HI on byte.
  - LEN_HI → N is checked:
    - N > WORDS → ERR.
    - N = 0 → DONE (CSUM if enabled).
    - Otherwise → DATA.
  - DATA:
    - A 2-bit byte index accumulates bytes into the word.
    - On the 4th byte, the next cycle drives o_Wr_en=1 with o_Wr_addr = word index and o_Wr_data = assembled word. Latency is 1 cycle after the 4th byte_valid.
    - Word index and o_Count increment after each write.
    - After the N-th write → DONE (CSUM if enabled).
  - DONE: o_Done=1, o_Cpu_hold=0. Further UART bytes are ignored.
  - ERR: o_Error=1, o_Cpu_hold=1, o_Wr_en stays 0. Further UART bytes are ignored.
  - i_Start in DONE or ERR → LEN_LO with cleared flags, o_Count=0 and o_Cpu_hold=1.
  - i_Start in any other state is ignored.
- Writes occur only at addresses 0..N-1; the address never wraps.
- o_Wr_en is never asserted for two consecutive cycles, since a byte takes ≥ 10·CLKS_PER_BIT cycles.
- A framing error during LEN or DATA → ERR. A partial word is discarded; words already written remain in memory.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word (or after LEN_HI when N=0), one extra byte is expected.
  - That byte must equal the XOR of all 4·N data bytes (0x00 when N=0).
  - Match → DONE; mismatch → ERR.
- Undefined: no CSUM state; the FSM goes directly to DONE.

Decomposition:
- Shared package imem_loader_pkg holds:
  - FSM state encoding (LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR).
  - UART bit-phase constants (start, data, stop).
- One sub-module, uart_rx_byte:
  - Contains the synchronizer, bit timer, and shift register.
  - Outputs o_Byte[7:0], o_Valid and o_Frame_err.
- The top-level FSM and word assembler stay in imem_uart_loader.

Test Plan (CLKS_PER_BIT=4, WORDS=8):
- Frame 02 00 | 20 00 08 00 | 0A 00 00 AC → two writes:
  - addr0 = 0x00080020, addr1 = 0xAC00000A.
  - Each o_Wr_en is 1 cycle; then o_Done=1, o_Cpu_hold=0, o_Count=2.
- Length 09 00 (> WORDS) → o_Error=1, no o_Wr_en ever, o_Cpu_hold=1.
- Stop bit forced 0 on the 3rd data byte → ERR, no write for the partial word, o_Count=0.
- 1-cycle low glitch on idle i_Rx → no byte, state stays LEN_LO, no error.
- i_Rst_n low midway through word 1 of a 2-word frame, then a full 1-word frame 01 00 EF BE AD DE → addr0 = 0xDEADBEEF, o_Done=1.
- IMEM_LOADER_CHECKSUM_EN: frame 01 00 11 22 33 44 + 0x44 → DONE; same frame + 0x45 → ERR. Then i_Start → LEN_LO with o_Error=0 and o_Cpu_hold=1.
